// File: rtl/ex_forward_interlock_if.sv
// Execute-stage forwarding/interlock bus: pipeline-side signals grouped
// so the pipeline drives the master side and the EX interlock block is the slave.
interface ex_forward_interlock_if #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
);
  logic            id_valid;
  logic [4:0]      id_rs1;
  logic [4:0]      id_rs2;
  logic            id_uses_rs1;
  logic            id_uses_rs2;
  logic            ex_valid;
  logic [4:0]      ex_rd;
  logic            ex_reg_wr;
  logic            ex_is_load;
  logic            ex_redirect;
  logic [1:0]      rs1_hazard;
  logic [1:0]      rs2_hazard;
  logic [XLEN-1:0] rf_rs1_data;
  logic [XLEN-1:0] rf_rs2_data;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] wb_data;
  logic            dmem_req;
  logic            dmem_ready;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            stall_if;
  logic            stall_id;
  logic            stall_ex;
  logic            bubble_ex;
  logic            flush_id;
  logic [XLEN-1:0] alu_q;
  logic [CNTW-1:0] stall_cycles;

  modport master (
    output id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_rd, ex_reg_wr, ex_is_load, ex_redirect,
           rs1_hazard, rs2_hazard, rf_rs1_data, rf_rs2_data,
           alu_result, wb_data, dmem_req, dmem_ready,
    input  op_a, op_b, stall_if, stall_id, stall_ex, bubble_ex,
           flush_id, alu_q, stall_cycles
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_uses_rs1, id_uses_rs2,
           ex_valid, ex_rd, ex_reg_wr, ex_is_load, ex_redirect,
           rs1_hazard, rs2_hazard, rf_rs1_data, rf_rs2_data,
           alu_result, wb_data, dmem_req, dmem_ready,
    output op_a, op_b, stall_if, stall_id, stall_ex, bubble_ex,
           flush_id, alu_q, stall_cycles
  );
endinterface

// File: rtl/ex_forward_interlock.sv
// EX-stage operand forwarding mux plus load-use / memory-wait / redirect
// interlock FSM and saturating stall-cycle counter.

// One ALU operand source select: 00/11 regfile, 01 previous ALU, 10 writeback.
module ex_fwd_mux #(
  parameter int XLEN = 32
) (
  input  logic [1:0]      sel,
  input  logic [XLEN-1:0] rf,
  input  logic [XLEN-1:0] aq,
  input  logic [XLEN-1:0] wb,
  output logic [XLEN-1:0] op
);
  // Reserved select 11 falls back to the register file.
  always_comb begin
    case (sel)
      2'b01:   op = aq;
      2'b10:   op = wb;
      default: op = rf;
    endcase
  end
endmodule

module ex_forward_interlock #(
  parameter int XLEN = 32,
  parameter int CNTW = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  ex_forward_interlock_if.slave bus
);
  localparam int NUM_OPS = 2;

  typedef enum logic {IDLE, MEM_WAIT} state_t;

  state_t                          state;
  logic                            redirect_pend;
  logic [XLEN-1:0]                 alu_q;
  logic [CNTW-1:0]                 stall_cnt;
  logic [NUM_OPS-1:0][1:0]         op_sel;
  logic [NUM_OPS-1:0][XLEN-1:0]    op_rf;
  logic [NUM_OPS-1:0][XLEN-1:0]    op_out;
  logic                            mem_busy;
  logic                            load_use;
  logic                            s_if, s_id, s_ex, bub, fl;

  assign op_sel = {bus.rs2_hazard, bus.rs1_hazard};
  assign op_rf  = {bus.rf_rs2_data, bus.rf_rs1_data};

  // Operand A is lane 0, operand B is lane 1; selects are independent.
  for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
    ex_fwd_mux #(.XLEN(XLEN)) u_mux (
      .sel (op_sel[i]),
      .rf  (op_rf[i]),
      .aq  (alu_q),
      .wb  (bus.wb_data),
      .op  (op_out[i])
    );
  end

  assign bus.op_a = op_out[0];
  assign bus.op_b = op_out[1];

  assign mem_busy = bus.dmem_req & ~bus.dmem_ready;

  // x0 is never a real producer, so it cannot create a load-use hazard.
  assign load_use = bus.ex_valid & bus.ex_is_load & bus.ex_reg_wr &
                    (bus.ex_rd != 5'd0) & bus.id_valid &
                    ((bus.id_uses_rs1 & (bus.id_rs1 == bus.ex_rd)) |
                     (bus.id_uses_rs2 & (bus.id_rs2 == bus.ex_rd)));

  // Control outputs react in the same cycle as the condition they cover.
  // Memory wait dominates; redirect beats load-use since the ID op is dead.
  always_comb begin
    s_if = 1'b0;
    s_id = 1'b0;
    s_ex = 1'b0;
    bub  = 1'b0;
    fl   = 1'b0;
    if (mem_busy) begin
      s_if = 1'b1;
      s_id = 1'b1;
      s_ex = 1'b1;
    end else if (state == MEM_WAIT) begin
      // Exit cycle: replay a redirect captured when the wait began.
      fl  = redirect_pend;
      bub = redirect_pend;
    end else if (bus.ex_redirect) begin
      fl  = 1'b1;
      bub = 1'b1;
    end else if (load_use) begin
      s_if = 1'b1;
      s_id = 1'b1;
      bub  = 1'b1;
    end
  end

  assign bus.stall_if  = s_if;
  assign bus.stall_id  = s_id;
  assign bus.stall_ex  = s_ex;
  assign bus.bubble_ex = bub;
  assign bus.flush_id  = fl;

  // Interlock FSM; redirect seen on wait entry is remembered, later ones ignored.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      redirect_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_busy) begin
            state         <= MEM_WAIT;
            redirect_pend <= bus.ex_redirect;
          end
        end
        MEM_WAIT: begin
          if (!mem_busy) begin
            state         <= IDLE;
            redirect_pend <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Previous ALU result for forwarding; frozen while EX is held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      alu_q <= '0;
    else if (!s_ex) alu_q <= bus.alu_result;
  end

  // Saturating count of cycles spent with ID held.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                    stall_cnt <= '0;
    else if (s_id && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.alu_q        = alu_q;
  assign bus.stall_cycles = stall_cnt;
endmodule

// File: tb/tb_ex_forward_interlock.sv
// Randomized and directed bench for ex_forward_interlock against a
// cycle-level reference model of the interlock rules.
module tb_ex_forward_interlock;
  localparam int XLEN = 32;
  localparam int CNTW = 16;
  localparam int CMAX = (1 << CNTW) - 1;

  logic clk;
  logic rstn;
  int   n_chk;
  int   n_err;

  ex_forward_interlock_if #(.XLEN(XLEN), .CNTW(CNTW)) bus ();

  ex_forward_interlock #(.XLEN(XLEN), .CNTW(CNTW)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  bit              m_wait;
  bit              m_rpend;
  logic [XLEN-1:0] m_aluq;
  int              m_cnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [XLEN-1:0] pick(input logic [1:0] s, input logic [XLEN-1:0] rf);
    if (s == 2'b01) return m_aluq;
    if (s == 2'b10) return bus.wb_data;
    return rf;
  endfunction

  // Expected {stall_if, stall_id, stall_ex, bubble_ex, flush_id}
  function automatic logic [4:0] exp_ctrl();
    bit busy, lu;
    busy = bus.dmem_req && !bus.dmem_ready;
    lu = bus.ex_valid && bus.ex_is_load && bus.ex_reg_wr && bus.ex_rd != 0 && bus.id_valid &&
         ((bus.id_uses_rs1 && bus.id_rs1 == bus.ex_rd) || (bus.id_uses_rs2 && bus.id_rs2 == bus.ex_rd));
    if (busy) return 5'b11100;
    if (m_wait) return m_rpend ? 5'b00011 : 5'b00000;
    if (bus.ex_redirect) return 5'b00011;
    if (lu) return 5'b11010;
    return 5'b00000;
  endfunction

  function automatic logic [4:0] act_ctrl();
    return {bus.stall_if, bus.stall_id, bus.stall_ex, bus.bubble_ex, bus.flush_id};
  endfunction

  task automatic mreset();
    m_wait = 0; m_rpend = 0; m_aluq = '0; m_cnt = 0;
  endtask

  // One cycle: check combinational/registered outputs mid-cycle, then advance model.
  task automatic tick();
    logic [4:0] ec;
    bit nw, nr;
    logic [XLEN-1:0] na;
    int nc;
    @(negedge clk);
    if (!rstn) mreset();
    ec = exp_ctrl();
    chk("op_a", bus.op_a, pick(bus.rs1_hazard, bus.rf_rs1_data));
    chk("op_b", bus.op_b, pick(bus.rs2_hazard, bus.rf_rs2_data));
    chk("ctrl", act_ctrl(), ec);
    chk("alu_q", bus.alu_q, m_aluq);
    chk("stall_cycles", bus.stall_cycles, m_cnt);
    nw = bus.dmem_req && !bus.dmem_ready;
    nr = m_rpend;
    if (!m_wait && nw) nr = bus.ex_redirect;
    else if (m_wait && !nw) nr = 0;
    na = ec[2] ? m_aluq : bus.alu_result;
    nc = (ec[3] && m_cnt < CMAX) ? m_cnt + 1 : m_cnt;
    @(posedge clk);
    if (rstn) begin
      m_wait = nw; m_rpend = nr; m_aluq = na; m_cnt = nc;
    end else mreset();
    #1;
  endtask

  task automatic idle_in();
    bus.id_valid = 0; bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_uses_rs1 = 0; bus.id_uses_rs2 = 0;
    bus.ex_valid = 0; bus.ex_rd = 0; bus.ex_reg_wr = 0; bus.ex_is_load = 0; bus.ex_redirect = 0;
    bus.rs1_hazard = 0; bus.rs2_hazard = 0; bus.rf_rs1_data = 0; bus.rf_rs2_data = 0;
    bus.alu_result = 0; bus.wb_data = 0; bus.dmem_req = 0; bus.dmem_ready = 0;
  endtask

  task automatic do_reset();
    rstn = 0; idle_in(); tick(); rstn = 1;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    bus.ex_valid = 1; bus.ex_is_load = 1; bus.ex_reg_wr = 1; bus.ex_rd = rd;
    bus.id_valid = 1; bus.id_uses_rs2 = 1; bus.id_rs2 = 5'd5;
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    mreset();
    rstn = 0;
    idle_in();
    #1;
    chk("reset_ctrl", act_ctrl(), 5'b0);
    chk("reset_aluq", bus.alu_q, 0);
    tick();
    rstn = 1;

    // Operand forwarding
    bus.alu_result = 32'h11; tick(); tick();
    bus.rs1_hazard = 2'b01; bus.rs2_hazard = 2'b10; bus.wb_data = 32'h22; #1;
    chk("fwd_op_a", bus.op_a, 32'h11);
    chk("fwd_op_b", bus.op_b, 32'h22);
    bus.rs1_hazard = 2'b11; bus.rf_rs1_data = 32'h33; #1;
    chk("rsvd_op_a", bus.op_a, 32'h33);
    tick();

    // Load-use one-cycle interlock
    do_reset();
    set_load_use(5'd5); #1;
    chk("lu_ctrl", act_ctrl(), 5'b11010);
    tick();
    idle_in(); tick();
    chk("lu_cnt", bus.stall_cycles, 1);
    set_load_use(5'd0); bus.id_rs2 = 5'd0; #1;
    chk("lu_x0_ctrl", act_ctrl(), 5'b0);
    tick(); idle_in();

    // Memory wait: three busy cycles then ready
    do_reset();
    bus.alu_result = 32'hA5; tick();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bus.alu_result = $urandom; tick();
    end
    chk("mw_aluq_hold", bus.alu_q, 32'hA5);
    bus.dmem_ready = 1; #1;
    chk("mw_release", act_ctrl(), 5'b0);
    tick();
    chk("mw_cnt", bus.stall_cycles, 3);
    idle_in();

    // Redirect captured on wait entry, replayed on exit only
    bus.dmem_req = 1; bus.ex_redirect = 1; tick();
    bus.ex_redirect = 0; tick();
    bus.dmem_ready = 1; #1;
    chk("rd_exit_ctrl", act_ctrl(), 5'b00011);
    tick(); idle_in(); #1;
    chk("rd_after_ctrl", act_ctrl(), 5'b0);
    tick();

    // Redirect beats load-use
    set_load_use(5'd5); bus.ex_redirect = 1; #1;
    chk("rd_lu_ctrl", act_ctrl(), 5'b00011);
    tick(); idle_in();

    // Reset in the middle of a memory wait
    bus.dmem_req = 1; tick(); tick();
    rstn = 0; bus.dmem_req = 0; #1;
    chk("rst_mw_ctrl", act_ctrl(), 5'b0);
    chk("rst_mw_cnt", bus.stall_cycles, 0);
    chk("rst_mw_aluq", bus.alu_q, 0);
    tick(); rstn = 1; tick();

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      bus.id_valid    = $urandom_range(0, 3) != 0;
      bus.id_rs1      = 5'($urandom_range(0, 3));
      bus.id_rs2      = 5'($urandom_range(0, 3));
      bus.id_uses_rs1 = 1'($urandom);
      bus.id_uses_rs2 = 1'($urandom);
      bus.ex_valid    = $urandom_range(0, 3) != 0;
      bus.ex_rd       = 5'($urandom_range(0, 3));
      bus.ex_reg_wr   = $urandom_range(0, 3) != 0;
      bus.ex_is_load  = $urandom_range(0, 2) == 0;
      bus.ex_redirect = $urandom_range(0, 5) == 0;
      bus.rs1_hazard  = 2'($urandom);
      bus.rs2_hazard  = 2'($urandom);
      bus.rf_rs1_data = $urandom;
      bus.rf_rs2_data = $urandom;
      bus.alu_result  = $urandom;
      bus.wb_data     = $urandom;
      bus.dmem_req    = $urandom_range(0, 3) == 0;
      bus.dmem_ready  = $urandom_range(0, 4) < 3;
      tick();
    end

    // Counter saturation
    do_reset();
    bus.dmem_req = 1; bus.dmem_ready = 0;
    for (int i = 0; i < (1 << 16) + 5; i++) begin
      @(posedge clk);
      if (m_cnt < CMAX) m_cnt++;
    end
    #1;
    m_wait = 1;
    chk("sat_cnt", bus.stall_cycles, 16'hFFFF);
    bus.dmem_ready = 1; tick();
    chk("sat_hold", bus.stall_cycles, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
